// File: rtl/counter_updown_mod_if.sv
// Control and status bundle for counter_updown_mod.
// The driver of CE/SLOAD/LOAD/D/UP takes the master side, and the counter takes the slave side.
interface counter_updown_mod_if #(
  parameter int unsigned WIDTH = 4
);
  logic             CE;
  logic             SLOAD;
  logic             LOAD;
  logic [WIDTH-1:0] D;
  logic             UP;
  logic [WIDTH-1:0] Q;
  logic             TC;
  logic             WRAP;

  modport master (
    output CE, SLOAD, LOAD, D, UP,
    input  Q, TC, WRAP
  );

  modport slave (
    input  CE, SLOAD, LOAD, D, UP,
    output Q, TC, WRAP
  );
endinterface

// File: rtl/counter_updown_mod.sv
// Up/down modulo-MODULUS counter with async clear, enable, constant/data loads,
// combinational terminal count and a registered one-cycle wrap flag.
module counter_updown_mod #(
  parameter int unsigned     WIDTH       = 4,
  parameter longint unsigned MODULUS     = 16,
  parameter int unsigned     LOAD_CONST  = 10,
  parameter int unsigned     RESET_VALUE = 0
) (
  input  logic                 C,
  input  logic                 CLRN,
  counter_updown_mod_if.slave  cnt
);

  // MODULUS may equal 2^WIDTH, so only MODULUS-1 is ever formed at WIDTH bits.
  localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] LOAD_Q  = WIDTH'(LOAD_CONST);
  localparam logic [WIDTH-1:0] RESET_Q = WIDTH'(RESET_VALUE);

  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q;
  logic             at_end;
  logic             tc;

  assign at_end = cnt.UP ? (q_q == MAX_Q) : (q_q == '0);
  assign tc     = cnt.CE & ~cnt.SLOAD & ~cnt.LOAD & at_end;

  // NOTE: q_d gets a default before any branch so no path leaves it unassigned (no latch).
  always_comb begin
    q_d = q_q;
    if (cnt.SLOAD) begin
      q_d = LOAD_Q;
    end else if (cnt.LOAD) begin
      q_d = (cnt.D > MAX_Q) ? MAX_Q : cnt.D;
    end else if (cnt.CE) begin
      if (cnt.UP) q_d = (q_q == MAX_Q) ? '0 : q_q + WIDTH'(1);
      else        q_d = (q_q == '0) ? MAX_Q : q_q - WIDTH'(1);
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge C or negedge CLRN) begin
    if (!CLRN) begin
      q_q    <= RESET_Q;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= tc;
    end
  end

  assign cnt.Q    = q_q;
  assign cnt.TC   = tc;
  assign cnt.WRAP = wrap_q;

endmodule

// File: tb/tb_counter_updown_mod.sv
// Scoreboard bench for counter_updown_mod: four configurations, directed steps then random traffic,
// each checked against a behavioural model of the modulo counter.
module tb_counter_updown_mod;

  logic       C = 1'b0;
  logic [3:0] rn;

  always #5 C = ~C;

  counter_updown_mod_if #(.WIDTH(4)) if0 ();
  counter_updown_mod_if #(.WIDTH(1)) if1 ();
  counter_updown_mod_if #(.WIDTH(4)) if2 ();
  counter_updown_mod_if #(.WIDTH(8)) if3 ();

  counter_updown_mod #(.WIDTH(4), .MODULUS(10),  .LOAD_CONST(7),   .RESET_VALUE(0))
    dut0 (.C(C), .CLRN(rn[0]), .cnt(if0.slave));
  counter_updown_mod #(.WIDTH(1), .MODULUS(2),   .LOAD_CONST(1),   .RESET_VALUE(0))
    dut1 (.C(C), .CLRN(rn[1]), .cnt(if1.slave));
  counter_updown_mod #(.WIDTH(4), .MODULUS(16),  .LOAD_CONST(10),  .RESET_VALUE(0))
    dut2 (.C(C), .CLRN(rn[2]), .cnt(if2.slave));
  counter_updown_mod #(.WIDTH(8), .MODULUS(200), .LOAD_CONST(150), .RESET_VALUE(100))
    dut3 (.C(C), .CLRN(rn[3]), .cnt(if3.slave));

  int mod_a [4] = '{10, 2, 16, 200};
  int lc_a  [4] = '{7, 1, 10, 150};
  int rv_a  [4] = '{0, 0, 0, 100};
  int wid_a [4] = '{4, 1, 4, 8};

  int mq [4];
  int mw [4];

  typedef enum int {F_Q = 0, F_TC = 1, F_WRAP = 2} field_e;
  typedef struct {
    int     k;
    field_e f;
    int     exp;
    string  tag;
  } sb_t;
  sb_t sb[$];

  int total = 0;
  int bad   = 0;

  function automatic int m_next(int k, int q, bit ce, bit sl, bit ld, int d, bit up);
    int m = mod_a[k];
    if (sl) return lc_a[k];
    if (ld) return (d >= m) ? m - 1 : d;
    if (ce) begin
      if (up) return (q == m - 1) ? 0 : q + 1;
      return (q == 0) ? m - 1 : q - 1;
    end
    return q;
  endfunction

  function automatic int m_tc(int k, int q, bit ce, bit sl, bit ld, bit up);
    return (ce && !sl && !ld && (up ? (q == mod_a[k] - 1) : (q == 0))) ? 1 : 0;
  endfunction

  function automatic logic [31:0] get_obs(int k, field_e f);
    logic [31:0] v = 'x;
    case (k)
      0: v = (f == F_Q) ? 32'(if0.Q) : (f == F_TC) ? 32'(if0.TC) : 32'(if0.WRAP);
      1: v = (f == F_Q) ? 32'(if1.Q) : (f == F_TC) ? 32'(if1.TC) : 32'(if1.WRAP);
      2: v = (f == F_Q) ? 32'(if2.Q) : (f == F_TC) ? 32'(if2.TC) : 32'(if2.WRAP);
      default: v = (f == F_Q) ? 32'(if3.Q) : (f == F_TC) ? 32'(if3.TC) : 32'(if3.WRAP);
    endcase
    return v;
  endfunction

  task automatic push(int k, field_e f, int exp, string tag);
    sb_t e;
    e.k = k; e.f = f; e.exp = exp; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drain();
    sb_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check($sformatf("d%0d_%s_%s", e.k, e.tag, e.f.name()), get_obs(e.k, e.f), 32'(e.exp));
    end
  endtask

  task automatic drive(int k, bit r, bit ce, bit sl, bit ld, int d, bit up);
    rn[k] = r;
    case (k)
      0: begin if0.CE = ce; if0.SLOAD = sl; if0.LOAD = ld; if0.D = 4'(d); if0.UP = up; end
      1: begin if1.CE = ce; if1.SLOAD = sl; if1.LOAD = ld; if1.D = 1'(d); if1.UP = up; end
      2: begin if2.CE = ce; if2.SLOAD = sl; if2.LOAD = ld; if2.D = 4'(d); if2.UP = up; end
      default: begin if3.CE = ce; if3.SLOAD = sl; if3.LOAD = ld; if3.D = 8'(d); if3.UP = up; end
    endcase
  endtask

  // One step: drive at the falling edge, check state and TC, clock once, check the result.
  task automatic step(string tag, int k, bit r, bit ce, bit sl, bit ld, int d, bit up);
    int dm = d & ((1 << wid_a[k]) - 1);
    int t;
    drive(k, r, ce, sl, ld, dm, up);
    if (!r) begin
      mq[k] = rv_a[k];
      mw[k] = 0;
    end
    t = m_tc(k, mq[k], ce, sl, ld, up);
    push(k, F_Q, mq[k], tag);
    push(k, F_WRAP, mw[k], tag);
    push(k, F_TC, t, tag);
    #1 drain();
    if (r) begin
      mq[k] = m_next(k, mq[k], ce, sl, ld, dm, up);
      mw[k] = t;
    end
    push(k, F_Q, mq[k], tag);
    push(k, F_WRAP, mw[k], tag);
    @(posedge C);
    #1 drain();
    check($sformatf("d%0d_%s_range", k, tag), 32'(get_obs(k, F_Q) < 32'(mod_a[k])), 32'd1);
    @(negedge C);
  endtask

  initial begin
    rn = '1;
    for (int k = 0; k < 4; k++) begin
      drive(k, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
      mq[k] = rv_a[k];
      mw[k] = 0;
    end
    #1 rn = '0;
    @(negedge C);

    // Reset defaults and async clear mid-count.
    step("reset", 0, 0, 1, 0, 0, 0, 1);
    for (int i = 0; i < 7; i++) step("count7", 0, 1, 1, 0, 0, 0, 1);
    check("q_at_7", get_obs(0, F_Q), 32'd7);
    step("clr_mid", 0, 0, 1, 0, 0, 0, 1);
    step("release", 0, 1, 1, 0, 0, 0, 1);
    check("q_after_release", get_obs(0, F_Q), 32'd1);

    // Up wrap over 25 edges from 0.
    step("rst_up", 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 25; i++) step("up_wrap", 0, 1, 1, 0, 0, 0, 1);
    check("q_after_25", get_obs(0, F_Q), 32'd5);

    // Down wrap from 0, then direction flip at 4.
    step("rst_dn", 0, 0, 0, 0, 0, 0, 0);
    step("dn_wrap", 0, 1, 1, 0, 0, 0, 0);
    check("q_dn_wrapped", get_obs(0, F_Q), 32'd9);
    check("wrap_dn_pulse", get_obs(0, F_WRAP), 32'd1);
    for (int i = 0; i < 5; i++) step("dn_to4", 0, 1, 1, 0, 0, 0, 0);
    step("dn_to3", 0, 1, 1, 0, 0, 0, 0);
    step("flip_up", 0, 1, 1, 0, 0, 0, 1);
    check("q_after_flip", get_obs(0, F_Q), 32'd4);

    // Load priority, clamp and load at terminal count.
    step("ld3", 0, 1, 0, 0, 1, 3, 1);
    step("sl_ld", 0, 1, 1, 1, 1, 6, 0);
    check("q_sload_wins", get_obs(0, F_Q), 32'd7);
    step("ld6", 0, 1, 0, 0, 1, 6, 1);
    step("ld13", 0, 1, 1, 0, 1, 13, 1);
    check("q_clamped", get_obs(0, F_Q), 32'd9);
    step("sl_at_tc", 0, 1, 1, 1, 0, 0, 1);
    step("after_sl", 0, 1, 0, 0, 0, 0, 1);
    check("wrap_after_load", get_obs(0, F_WRAP), 32'd0);

    // Hold and alternating enable.
    for (int i = 0; i < 5; i++) step("hold7", 0, 1, 0, 0, 0, 0, 1);
    step("rst_tog", 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 10; i++) step("ce_tog", 0, 1, (i % 2) == 0, 0, 0, 0, 1);
    check("q_after_toggle", get_obs(0, F_Q), 32'd5);

    // Random traffic on every configuration.
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 1500; i++) begin
        step("rand", k, $urandom_range(49) != 0, $urandom_range(3) != 0,
             $urandom_range(7) == 0, $urandom_range(7) == 0,
             int'($urandom_range(255)), 1'($urandom_range(1)));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
